// File: rtl/ear_tape_conditioner_pkg.sv
// ear_tape_pkg
// Shared definitions for the EAR tape conditioner:
//   - MODE_* : encoding of the 2-bit source select input
//   - perState_e : states of the edge-period measurement FSM
package ear_tape_pkg;

  localparam logic [1:0] MODE_PIN  = 2'd0;
  localparam logic [1:0] MODE_ADC  = 2'd1;
  localparam logic [1:0] MODE_AUTO = 2'd2;
  localparam logic [1:0] MODE_OFF  = 2'd3;

  // ARMED behaves like IDLE but is entered after a source change, so the
  // first edge on the new source only starts a measurement.
  typedef enum logic [1:0] {
    PER_IDLE    = 2'd0,
    PER_ARMED   = 2'd1,
    PER_MEASURE = 2'd2
  } perState_e;

endpackage

// File: rtl/ear_tape_conditioner_glitch_filter.sv
// ear_glitch_filter
// Accepts a new level only after it has persisted for FILT_LEN consecutive
// ce ticks.
// Ports:
//   clk_sys_i    system clock
//   reset_i      synchronous reset, active high
//   ce_i         tick enable; the filter only advances when high
//   cand_i       raw candidate level
//   level_o      accepted level (registered)
//   levelNext_o  accepted level as it will be after this clock edge
//   acceptEdge_o high in the cycle whose clock edge toggles the accepted level
module ear_glitch_filter #(
  parameter int FILT_LEN = 4
) (
  input  logic clk_sys_i,
  input  logic reset_i,
  input  logic ce_i,
  input  logic cand_i,
  output logic level_o,
  output logic levelNext_o,
  output logic acceptEdge_o
);

  localparam logic [3:0] CNT_LAST = 4'(FILT_LEN - 1);

  logic [3:0] cnt_q, cnt_d;
  logic       level_q, level_d;
  logic       acceptEdge;

  // The counter tracks how many ticks the mismatch has already lasted, so
  // the toggle lands on the FILT_LEN-th mismatching tick.
  always_comb begin
    cnt_d      = cnt_q;
    level_d    = level_q;
    acceptEdge = 1'b0;
    if (ce_i) begin
      if (cand_i != level_q) begin
        if (cnt_q == CNT_LAST) begin
          level_d    = ~level_q;
          cnt_d      = '0;
          acceptEdge = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  // Filter state register.
  always_ff @(posedge clk_sys_i) begin
    if (reset_i) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level_o      = level_q;
  assign levelNext_o  = level_d;
  assign acceptEdge_o = acceptEdge;

endmodule

// File: rtl/ear_tape_conditioner.sv
// ear_tape_conditioner
// Turns the tape input (digital pin or ADC sample stream) into a clean EAR
// bit for the Lynx core, and measures the period between accepted edges.
// Ports:
//   clk_sys_i, reset_i      clock and synchronous active-high reset
//   ce_i                    tick enable for filter and counters
//   mode_i                  0 pin, 1 ADC, 2 auto, 3 off
//   invert_i                invert ear_out_o
//   pin_in_i                asynchronous digital tape input
//   adc_valid_i/adc_data_i  ADC sample strobe and value
//   thr_hi_i/thr_lo_i       Schmitt rising/falling thresholds
//   ear_out_o               conditioned EAR bit
//   edge_strobe_o           pulse on each accepted edge
//   period_o/period_valid_o ticks between the last two edges, update pulse
//   active_o                an edge occurred within ACT_TIMEOUT ticks
//   overflow_o              sticky period counter saturation
//   adc_sel_o               currently selected source (1 = ADC)
module ear_tape_conditioner
  import ear_tape_pkg::*;
#(
  parameter int ADC_W       = 12,
  parameter int FILT_LEN    = 4,
  parameter int PER_W       = 16,
  parameter int ACT_TIMEOUT = 65535
) (
  input  logic             clk_sys_i,
  input  logic             reset_i,
  input  logic             ce_i,
  input  logic [1:0]       mode_i,
  input  logic             invert_i,
  input  logic             pin_in_i,
  input  logic             adc_valid_i,
  input  logic [ADC_W-1:0] adc_data_i,
  input  logic [ADC_W-1:0] thr_hi_i,
  input  logic [ADC_W-1:0] thr_lo_i,
  output logic             ear_out_o,
  output logic             edge_strobe_o,
  output logic [PER_W-1:0] period_o,
  output logic             period_valid_o,
  output logic             active_o,
  output logic             overflow_o,
  output logic             adc_sel_o
);

  localparam int               ACT_W      = $clog2(ACT_TIMEOUT + 1);
  localparam logic [ACT_W-1:0] ACT_RELOAD = ACT_W'(ACT_TIMEOUT);
  localparam logic [PER_W-1:0] PER_MAX    = '1;

  logic             pinMeta_q, pinSync_q;
  logic [1:0]       mode_q, modePrev_q;
  logic             modeChange;
  logic             adcState_q, adcState_d, adcToggle;
  logic [ACT_W-1:0] adcAct_q, adcAct_d;
  logic             wantAdc;
  logic             adcSel_q, adcSel_d;
  logic             cand;
  logic             acceptLevel, acceptLevelNext, acceptEdge;
  logic             earOut_q, edgeStrobe_q;
  logic [ACT_W-1:0] actCnt_q, actCnt_d;
  perState_e        state_q, state_d;
  logic [PER_W-1:0] perCnt_q, perCnt_d, period_q, period_d, cntInc;
  logic             cntSat;
  logic             periodValid_q, periodValid_d, overflow_q, overflow_d;

  assign modeChange = (mode_q != modePrev_q);
  assign adcToggle  = (adcState_d != adcState_q);
  assign wantAdc    = (adcAct_q != '0);

  // Schmitt trigger; crossed thresholds collapse to a single threshold.
  always_comb begin
    adcState_d = adcState_q;
    if (adc_valid_i) begin
      if (thr_lo_i >= thr_hi_i) begin
        adcState_d = (adc_data_i >= thr_hi_i);
      end else if (adc_data_i >= thr_hi_i) begin
        adcState_d = 1'b1;
      end else if (adc_data_i <= thr_lo_i) begin
        adcState_d = 1'b0;
      end
    end
  end

  // Auto select only switches when the accepted level already matches the
  // new source, so the switch itself never creates an edge.
  always_comb begin
    adcAct_d = adcAct_q;
    if (adcToggle) begin
      adcAct_d = ACT_RELOAD;
    end else if (ce_i && wantAdc) begin
      adcAct_d = adcAct_q - 1'b1;
    end
    adcSel_d = adcSel_q;
    if (mode_q == MODE_AUTO) begin
      if (acceptLevel == (wantAdc ? adcState_q : pinSync_q)) begin
        adcSel_d = wantAdc;
      end
    end else begin
      adcSel_d = (mode_q == MODE_ADC);
    end
  end

  // Raw candidate level feeding the glitch filter.
  always_comb begin
    cand = 1'b0;
    case (mode_q)
      MODE_PIN:  cand = pinSync_q;
      MODE_ADC:  cand = adcState_q;
      MODE_AUTO: cand = adcSel_q ? adcState_q : pinSync_q;
      default:   cand = 1'b0;
    endcase
  end

  ear_glitch_filter #(
    .FILT_LEN(FILT_LEN)
  ) u_filter (
    .clk_sys_i   (clk_sys_i),
    .reset_i     (reset_i),
    .ce_i        (ce_i),
    .cand_i      (cand),
    .level_o     (acceptLevel),
    .levelNext_o (acceptLevelNext),
    .acceptEdge_o(acceptEdge)
  );

  // Activity timeout: reloaded on every accepted edge.
  always_comb begin
    actCnt_d = actCnt_q;
    if (acceptEdge) begin
      actCnt_d = ACT_RELOAD;
    end else if (ce_i && (actCnt_q != '0)) begin
      actCnt_d = actCnt_q - 1'b1;
    end
  end

  // Input synchroniser, mode sampling, source select and output bits.
  // ear_out is taken from the filter's next level so it changes in the same
  // cycle as edge_strobe.
  always_ff @(posedge clk_sys_i) begin
    if (reset_i) begin
      pinMeta_q    <= 1'b0;
      pinSync_q    <= 1'b0;
      mode_q       <= MODE_PIN;
      modePrev_q   <= MODE_PIN;
      adcState_q   <= 1'b0;
      adcAct_q     <= '0;
      adcSel_q     <= 1'b0;
      earOut_q     <= 1'b0;
      edgeStrobe_q <= 1'b0;
      actCnt_q     <= '0;
    end else begin
      pinMeta_q    <= pin_in_i;
      pinSync_q    <= pinMeta_q;
      mode_q       <= mode_i;
      modePrev_q   <= mode_q;
      adcState_q   <= adcState_d;
      adcAct_q     <= adcAct_d;
      adcSel_q     <= adcSel_d;
      earOut_q     <= acceptLevelNext ^ invert_i;
      edgeStrobe_q <= acceptEdge;
      actCnt_q     <= actCnt_d;
    end
  end

  // Period FSM state register.
  always_ff @(posedge clk_sys_i) begin
    if (reset_i) begin
      state_q <= PER_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Period FSM next state. A timed-out MEASURE drops to IDLE unless an edge
  // arrives that same cycle, in which case that edge restarts measurement.
  always_comb begin
    state_d = state_q;
    if (modeChange) begin
      state_d = PER_ARMED;
    end else begin
      case (state_q)
        PER_IDLE, PER_ARMED: if (acceptEdge) state_d = PER_MEASURE;
        PER_MEASURE: if ((actCnt_q == '0) && !acceptEdge) state_d = PER_IDLE;
        default: state_d = PER_IDLE;
      endcase
    end
  end

  // Period FSM outputs: the edge tick itself is counted in the period.
  always_comb begin
    cntSat        = (perCnt_q == PER_MAX);
    cntInc        = cntSat ? PER_MAX : perCnt_q + 1'b1;
    perCnt_d      = perCnt_q;
    period_d      = period_q;
    periodValid_d = 1'b0;
    overflow_d    = overflow_q;
    if (modeChange) begin
      perCnt_d   = '0;
      overflow_d = 1'b0;
    end else begin
      case (state_q)
        PER_MEASURE: begin
          if (acceptEdge) begin
            perCnt_d = '0;
            if (actCnt_q != '0) begin
              period_d      = cntInc;
              periodValid_d = 1'b1;
              if (cntSat) overflow_d = 1'b1;
            end
          end else if (ce_i) begin
            perCnt_d = cntInc;
            if (cntSat) overflow_d = 1'b1;
          end
        end
        default: if (acceptEdge) perCnt_d = '0;
      endcase
    end
  end

  // Period datapath registers.
  always_ff @(posedge clk_sys_i) begin
    if (reset_i) begin
      perCnt_q      <= '0;
      period_q      <= '0;
      periodValid_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      perCnt_q      <= perCnt_d;
      period_q      <= period_d;
      periodValid_q <= periodValid_d;
      overflow_q    <= overflow_d;
    end
  end

  assign ear_out_o      = earOut_q;
  assign edge_strobe_o  = edgeStrobe_q;
  assign period_o       = period_q;
  assign period_valid_o = periodValid_q;
  assign active_o       = (actCnt_q != '0);
  assign overflow_o     = overflow_q;
  assign adc_sel_o      = adcSel_q;

endmodule

// File: tb/tb_ear_tape_conditioner.sv
// tb_ear_tape_conditioner
// Directed bench with two instances sharing all inputs: dutA has a long
// activity timeout for period/overflow work, dutB a 50-tick timeout for the
// auto-select and timeout scenarios.
module tb_ear_tape_conditioner;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ce = 1'b1;
  logic [1:0]  mode = 2'd0;
  logic        invert = 1'b0;
  logic        pin_in = 1'b0;
  logic        adc_valid = 1'b0;
  logic [11:0] adc_data = '0;
  logic [11:0] thr_hi = 12'h900;
  logic [11:0] thr_lo = 12'h700;

  logic       earA, edgeA, pvA, activeA, ovfA, selA;
  logic [7:0] periodA;
  logic       earB, edgeB, pvB, activeB, ovfB, selB;
  logic [7:0] periodB;

  int total = 0;
  int bad = 0;

  always #5 clk_sys = ~clk_sys;

  ear_tape_conditioner #(
    .ADC_W(12), .FILT_LEN(4), .PER_W(8), .ACT_TIMEOUT(1000)
  ) dutA (
    .clk_sys_i(clk_sys), .reset_i(reset), .ce_i(ce), .mode_i(mode),
    .invert_i(invert), .pin_in_i(pin_in), .adc_valid_i(adc_valid),
    .adc_data_i(adc_data), .thr_hi_i(thr_hi), .thr_lo_i(thr_lo),
    .ear_out_o(earA), .edge_strobe_o(edgeA), .period_o(periodA),
    .period_valid_o(pvA), .active_o(activeA), .overflow_o(ovfA),
    .adc_sel_o(selA)
  );

  ear_tape_conditioner #(
    .ADC_W(12), .FILT_LEN(4), .PER_W(8), .ACT_TIMEOUT(50)
  ) dutB (
    .clk_sys_i(clk_sys), .reset_i(reset), .ce_i(ce), .mode_i(mode),
    .invert_i(invert), .pin_in_i(pin_in), .adc_valid_i(adc_valid),
    .adc_data_i(adc_data), .thr_hi_i(thr_hi), .thr_lo_i(thr_lo),
    .ear_out_o(earB), .edge_strobe_o(edgeB), .period_o(periodB),
    .period_valid_o(pvB), .active_o(activeB), .overflow_o(ovfB),
    .adc_sel_o(selB)
  );

  // Advance n clocks and settle 1ns past the last rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic doReset;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic applyStimulus(input logic [11:0] val);
    adc_data  = val;
    adc_valid = 1'b1;
    tick(1);
    adc_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(3);
    total++; if (earA !== 1'b0) begin bad++; $display("[TB] FAIL rst_ear got=%b want=0", earA); end
    total++; if (edgeA !== 1'b0) begin bad++; $display("[TB] FAIL rst_edge got=%b want=0", edgeA); end
    total++; if (periodA !== 8'd0) begin bad++; $display("[TB] FAIL rst_period got=%0d want=0", periodA); end
    total++; if (pvA !== 1'b0) begin bad++; $display("[TB] FAIL rst_pv got=%b want=0", pvA); end
    total++; if (activeA !== 1'b0) begin bad++; $display("[TB] FAIL rst_active got=%b want=0", activeA); end
    total++; if (ovfA !== 1'b0) begin bad++; $display("[TB] FAIL rst_ovf got=%b want=0", ovfA); end
    total++; if (selB !== 1'b0) begin bad++; $display("[TB] FAIL rst_sel got=%b want=0", selB); end
    reset = 1'b0;
  endtask

  task automatic test_pin_square;
    logic lvl;
    logic expPv;
    mode = 2'd0; invert = 1'b0; pin_in = 1'b0;
    doReset;
    tick(20);
    lvl = 1'b0;
    for (int k = 0; k < 4; k++) begin
      lvl = ~lvl;
      pin_in = lvl;
      expPv = (k > 0);
      tick(5);
      total++; if (earA !== ~lvl) begin bad++; $display("[TB] FAIL sq_early k=%0d got=%b want=%b", k, earA, ~lvl); end
      tick(1);
      total++; if (earA !== lvl) begin bad++; $display("[TB] FAIL sq_ear k=%0d got=%b want=%b", k, earA, lvl); end
      total++; if (edgeA !== 1'b1) begin bad++; $display("[TB] FAIL sq_edge k=%0d got=%b want=1", k, edgeA); end
      total++; if (pvA !== expPv) begin bad++; $display("[TB] FAIL sq_pv k=%0d got=%b want=%b", k, pvA, expPv); end
      if (k > 0) begin
        total++; if (periodA !== 8'd100) begin bad++; $display("[TB] FAIL sq_period k=%0d got=%0d want=100", k, periodA); end
      end
      tick(94);
    end
    total++; if (activeA !== 1'b1) begin bad++; $display("[TB] FAIL sq_active got=%b want=1", activeA); end
  endtask

  task automatic test_glitch;
    int edges;
    int highs;
    mode = 2'd0; pin_in = 1'b0;
    doReset;
    tick(10);
    pin_in = 1'b1; tick(3); pin_in = 1'b0;
    edges = 0; highs = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      edges += int'(edgeA);
      highs += int'(earA);
    end
    total++; if (edges != 0) begin bad++; $display("[TB] FAIL glitch3_edges got=%0d want=0", edges); end
    total++; if (highs != 0) begin bad++; $display("[TB] FAIL glitch3_ear got=%0d want=0", highs); end
    pin_in = 1'b1; tick(4); pin_in = 1'b0;
    edges = 0; highs = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      edges += int'(edgeA);
      highs += int'(earA);
    end
    total++; if (edges != 2) begin bad++; $display("[TB] FAIL glitch4_edges got=%0d want=2", edges); end
    total++; if (highs != 4) begin bad++; $display("[TB] FAIL glitch4_ear got=%0d want=4", highs); end
  endtask

  task automatic test_overflow;
    mode = 2'd0; pin_in = 1'b0;
    doReset;
    tick(10);
    pin_in = 1'b1; tick(6);
    total++; if (edgeA !== 1'b1) begin bad++; $display("[TB] FAIL ovf_first_edge got=%b want=1", edgeA); end
    total++; if (pvA !== 1'b0) begin bad++; $display("[TB] FAIL ovf_first_pv got=%b want=0", pvA); end
    tick(294);
    pin_in = 1'b0; tick(6);
    total++; if (pvA !== 1'b1) begin bad++; $display("[TB] FAIL ovf_pv got=%b want=1", pvA); end
    total++; if (periodA !== 8'd255) begin bad++; $display("[TB] FAIL ovf_period got=%0d want=255", periodA); end
    total++; if (ovfA !== 1'b1) begin bad++; $display("[TB] FAIL ovf_flag got=%b want=1", ovfA); end
    mode = 2'd2; tick(3);
    total++; if (ovfA !== 1'b0) begin bad++; $display("[TB] FAIL ovf_clear got=%b want=0", ovfA); end
    pin_in = 1'b1; tick(6);
    total++; if (edgeA !== 1'b1) begin bad++; $display("[TB] FAIL ovf_armed_edge got=%b want=1", edgeA); end
    total++; if (pvA !== 1'b0) begin bad++; $display("[TB] FAIL ovf_armed_pv got=%b want=0", pvA); end
    tick(44);
    pin_in = 1'b0; tick(6);
    total++; if (pvA !== 1'b1) begin bad++; $display("[TB] FAIL ovf_rearm_pv got=%b want=1", pvA); end
    total++; if (periodA !== 8'd50) begin bad++; $display("[TB] FAIL ovf_rearm_period got=%0d want=50", periodA); end
  endtask

  task automatic test_adc_hysteresis;
    logic [11:0] samp [6];
    logic        expv [6];
    samp[0] = 12'h800; expv[0] = 1'b0;
    samp[1] = 12'hA00; expv[1] = 1'b1;
    samp[2] = 12'h800; expv[2] = 1'b1;
    samp[3] = 12'h600; expv[3] = 1'b0;
    samp[4] = 12'h950; expv[4] = 1'b1;
    samp[5] = 12'h8FF; expv[5] = 1'b0;
    mode = 2'd1; pin_in = 1'b0; thr_hi = 12'h900; thr_lo = 12'h700;
    doReset;
    tick(5);
    for (int i = 0; i < 6; i++) begin
      if (i == 4) thr_lo = 12'hA00;
      applyStimulus(samp[i]);
      tick(8);
      total++; if (earA !== expv[i]) begin bad++; $display("[TB] FAIL adc_hyst i=%0d sample=%h got=%b want=%b", i, samp[i], earA, expv[i]); end
    end
    thr_lo = 12'h700;
  endtask

  task automatic test_auto_timeout;
    mode = 2'd2; pin_in = 1'b0; thr_hi = 12'h900; thr_lo = 12'h700;
    doReset;
    tick(5);
    applyStimulus(12'hA00); tick(3);
    total++; if (selB !== 1'b0) begin bad++; $display("[TB] FAIL auto_guard got=%b want=0", selB); end
    applyStimulus(12'h600); tick(3);
    total++; if (selB !== 1'b1) begin bad++; $display("[TB] FAIL auto_sel got=%b want=1", selB); end
    total++; if (earB !== 1'b0) begin bad++; $display("[TB] FAIL auto_switch_ear got=%b want=0", earB); end
    applyStimulus(12'hA00); tick(4);
    total++; if (earB !== 1'b1) begin bad++; $display("[TB] FAIL auto_adc_ear got=%b want=1", earB); end
    total++; if (pvB !== 1'b0) begin bad++; $display("[TB] FAIL auto_first_pv got=%b want=0", pvB); end
    tick(15);
    applyStimulus(12'h600); tick(4);
    total++; if (edgeB !== 1'b1) begin bad++; $display("[TB] FAIL auto_edge got=%b want=1", edgeB); end
    total++; if (periodB !== 8'd20) begin bad++; $display("[TB] FAIL auto_period got=%0d want=20", periodB); end
    tick(60);
    total++; if (selB !== 1'b0) begin bad++; $display("[TB] FAIL auto_sel_drop got=%b want=0", selB); end
    total++; if (activeB !== 1'b0) begin bad++; $display("[TB] FAIL auto_active_drop got=%b want=0", activeB); end
    pin_in = 1'b1; tick(6);
    total++; if (edgeB !== 1'b1) begin bad++; $display("[TB] FAIL auto_pin_edge got=%b want=1", edgeB); end
    total++; if (pvB !== 1'b0) begin bad++; $display("[TB] FAIL auto_idle_pv got=%b want=0", pvB); end
  endtask

  task automatic test_reset_off;
    mode = 2'd0; invert = 1'b0; pin_in = 1'b0;
    doReset;
    tick(5);
    pin_in = 1'b1; tick(6);
    pin_in = 1'b0; tick(6);
    pin_in = 1'b1; tick(16);
    reset = 1'b1; tick(1);
    total++; if (earA !== 1'b0) begin bad++; $display("[TB] FAIL midrst_ear got=%b want=0", earA); end
    total++; if (pvA !== 1'b0) begin bad++; $display("[TB] FAIL midrst_pv got=%b want=0", pvA); end
    total++; if (periodA !== 8'd0) begin bad++; $display("[TB] FAIL midrst_period got=%0d want=0", periodA); end
    total++; if (activeA !== 1'b0) begin bad++; $display("[TB] FAIL midrst_active got=%b want=0", activeA); end
    invert = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(10);
    total++; if (earA !== 1'b0) begin bad++; $display("[TB] FAIL inv_ear got=%b want=0", earA); end
    mode = 2'd3; tick(3);
    total++; if (earA !== 1'b0) begin bad++; $display("[TB] FAIL off_early got=%b want=0", earA); end
    tick(3);
    total++; if (earA !== 1'b1) begin bad++; $display("[TB] FAIL off_ear got=%b want=1", earA); end
    invert = 1'b0; mode = 2'd0;
  endtask

  // Hard stop in case a scenario stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Scenario sequence.
  initial begin
    test_reset;
    test_pin_square;
    test_glitch;
    test_overflow;
    test_adc_hysteresis;
    test_auto_timeout;
    test_reset_off;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
